// File: rtl/mmult_seq_pkg.sv
// Shared types and helpers for the tiled matrix-multiply sequencer.
package mmult_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INITC   = 3'd1,
        READ    = 3'd2,
        INITREG = 3'd3,
        SYS     = 3'd4,
        WRITEC  = 3'd5,
        DONE    = 3'd6
    } seq_state_e;

    // Child engine slots in the handshake vectors
    localparam int NUM_CH     = 6;
    localparam int CH_INITC   = 0;
    localparam int CH_READA   = 1;
    localparam int CH_READB   = 2;
    localparam int CH_INITREG = 3;
    localparam int CH_SYS     = 4;
    localparam int CH_WRITEC  = 5;

    typedef struct packed {
        logic [31:0] m;
        logic [31:0] n;
    } tile_pos_t;

    // Advance (m,n) in row-major tile order; n wraps and carries into m.
    function automatic tile_pos_t next_tile(input logic [31:0] m,
                                            input logic [31:0] n,
                                            input logic [31:0] n_tiles);
        tile_pos_t r;
        if (n == n_tiles - 32'd1) begin
            r.m = m + 32'd1;
            r.n = 32'd0;
        end else begin
            r.m = m;
            r.n = n + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mmult_tile_sequencer_hs.sv
// One ap_start/ap_done handshake: registered start plus a done-seen flag.
module mmult_child_hs (
    input  logic clock_i,
    input  logic reset_i,
    input  logic go_i,
    input  logic done_i,
    input  logic clear_i,
    output logic start_o,
    output logic seen_o,
    output logic accept_o
);

    logic start_q, start_d;
    logic seen_q, seen_d;

    // A done only counts while our start is high.
    assign accept_o = start_q & done_i;

    // Next-state for start (set by go, dropped on accepted done) and seen flag.
    always_comb begin
        start_d = start_q;
        seen_d  = seen_q;
        if (go_i) begin
            start_d = 1'b1;
        end else if (accept_o) begin
            start_d = 1'b0;
        end else begin
            start_d = start_q;
        end
        if (go_i || clear_i) begin
            seen_d = 1'b0;
        end else if (accept_o) begin
            seen_d = 1'b1;
        end else begin
            seen_d = seen_q;
        end
    end

    // Handshake state registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            start_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            seen_q  <= seen_d;
        end
    end

    assign start_o = start_q;
    assign seen_o  = seen_q;

endmodule

// File: rtl/mmult_tile_sequencer.sv
// Top-level control FSM sequencing the six mmult child engines over all tiles.
module mmult_tile_sequencer
    import mmult_seq_pkg::*;
#(
    parameter int M_TILES = 4,
    parameter int N_TILES = 4,
    parameter int K_TILES = 4,
    parameter int IDX_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic             initc_start,
    input  logic             initc_done,
    output logic             reada_start,
    input  logic             reada_done,
    output logic             readb_start,
    input  logic             readb_done,
    output logic             initreg_start,
    input  logic             initreg_done,
    output logic             sys_start,
    input  logic             sys_done,
    output logic             writec_start,
    input  logic             writec_done,
    output logic [IDX_W-1:0] m_idx,
    output logic [IDX_W-1:0] n_idx,
    output logic [IDX_W-1:0] k_idx
);

    localparam logic [IDX_W-1:0] M_LAST   = IDX_W'(M_TILES - 1);
    localparam logic [IDX_W-1:0] N_LAST   = IDX_W'(N_TILES - 1);
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(K_TILES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
    logic             ap_done_q, ap_done_d;
    logic             ap_idle_q, ap_idle_d;
    tile_pos_t        nt_s;

    logic [NUM_CH-1:0] go_s, clear_s, done_s, start_s, seen_s, accept_s, ok_s;

    assign done_s = {writec_done, sys_done, initreg_done, readb_done, reada_done, initc_done};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_hs
        mmult_child_hs u_hs (
            .clock_i  (clock),
            .reset_i  (reset),
            .go_i     (go_s[i]),
            .done_i   (done_s[i]),
            .clear_i  (clear_s[i]),
            .start_o  (start_s[i]),
            .seen_o   (seen_s[i]),
            .accept_o (accept_s[i])
        );
    end

    // A child has finished if its done is accepted now or was latched earlier.
    assign ok_s = seen_s | accept_s;

    // Next-state, tile index and child-launch decode.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        k_d     = k_q;
        go_s    = {NUM_CH{1'b0}};
        clear_s = {NUM_CH{1'b0}};
        nt_s    = next_tile(32'(m_q), 32'(n_q), N_TILES);
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    state_d            = INITC;
                    m_d                = IDX_ZERO;
                    n_d                = IDX_ZERO;
                    k_d                = IDX_ZERO;
                    go_s[CH_INITC]     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            INITC: begin
                if (ok_s[CH_INITC]) begin
                    state_d            = READ;
                    k_d                = IDX_ZERO;
                    clear_s[CH_INITC]  = 1'b1;
                    go_s[CH_READA]     = 1'b1;
                    go_s[CH_READB]     = 1'b1;
                end else begin
                    state_d = INITC;
                end
            end
            READ: begin
                // The two readers finish independently; leave once both have.
                if (ok_s[CH_READA] && ok_s[CH_READB]) begin
                    state_d             = INITREG;
                    clear_s[CH_READA]   = 1'b1;
                    clear_s[CH_READB]   = 1'b1;
                    go_s[CH_INITREG]    = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            INITREG: begin
                if (ok_s[CH_INITREG]) begin
                    state_d             = SYS;
                    clear_s[CH_INITREG] = 1'b1;
                    go_s[CH_SYS]        = 1'b1;
                end else begin
                    state_d = INITREG;
                end
            end
            SYS: begin
                if (ok_s[CH_SYS]) begin
                    clear_s[CH_SYS] = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d           = WRITEC;
                        go_s[CH_WRITEC]   = 1'b1;
                    end else begin
                        state_d           = READ;
                        k_d               = k_q + IDX_ONE;
                        go_s[CH_READA]    = 1'b1;
                        go_s[CH_READB]    = 1'b1;
                    end
                end else begin
                    state_d = SYS;
                end
            end
            WRITEC: begin
                if (ok_s[CH_WRITEC]) begin
                    clear_s[CH_WRITEC] = 1'b1;
                    if ((n_q == N_LAST) && (m_q == M_LAST)) begin
                        state_d = DONE;
                    end else begin
                        state_d        = INITC;
                        m_d            = IDX_W'(nt_s.m);
                        n_d            = IDX_W'(nt_s.n);
                        k_d            = IDX_ZERO;
                        go_s[CH_INITC] = 1'b1;
                    end
                end else begin
                    state_d = WRITEC;
                end
            end
            DONE: begin
                // ap_start is deliberately not looked at here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ap_done_d = (state_d == DONE);
        ap_idle_d = (state_d == IDLE);
    end

    // State, index and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            m_q       <= IDX_ZERO;
            n_q       <= IDX_ZERO;
            k_q       <= IDX_ZERO;
            ap_done_q <= 1'b0;
            ap_idle_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            n_q       <= n_d;
            k_q       <= k_d;
            ap_done_q <= ap_done_d;
            ap_idle_q <= ap_idle_d;
        end
    end

    assign ap_done       = ap_done_q;
    assign ap_ready      = ap_done_q;
    assign ap_idle       = ap_idle_q;
    assign initc_start   = start_s[CH_INITC];
    assign reada_start   = start_s[CH_READA];
    assign readb_start   = start_s[CH_READB];
    assign initreg_start = start_s[CH_INITREG];
    assign sys_start     = start_s[CH_SYS];
    assign writec_start  = start_s[CH_WRITEC];
    assign m_idx         = m_q;
    assign n_idx         = n_q;
    assign k_idx         = k_q;

endmodule

// File: tb/tb_mmult_tile_sequencer.sv
// Directed self-checking bench for mmult_tile_sequencer (M=2, N=2, K=3).
module tb_mmult_tile_sequencer;
    import mmult_seq_pkg::*;

    localparam int M = 2;
    localparam int N = 2;
    localparam int K = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       ap_start;
    logic       ap_done, ap_ready, ap_idle;
    logic       initc_start, reada_start, readb_start, initreg_start, sys_start, writec_start;
    logic       initc_done, reada_done, readb_done, initreg_done, sys_done, writec_done;
    logic [7:0] m_idx, n_idx, k_idx;

    always #5 clock = ~clock;

    mmult_tile_sequencer #(.M_TILES(M), .N_TILES(N), .K_TILES(K), .IDX_W(8)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .initc_start(initc_start), .initc_done(initc_done),
        .reada_start(reada_start), .reada_done(reada_done),
        .readb_start(readb_start), .readb_done(readb_done),
        .initreg_start(initreg_start), .initreg_done(initreg_done),
        .sys_start(sys_start), .sys_done(sys_done),
        .writec_start(writec_start), .writec_done(writec_done),
        .m_idx(m_idx), .n_idx(n_idx), .k_idx(k_idx)
    );

    typedef struct {
        logic [5:0] mask;
        int         m;
        int         n;
        int         k;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    string      cur_test = "reset";
    logic [5:0] prev_st, prev_dn, force_dn;
    logic [7:0] prev_m, prev_n, prev_k;
    int         cnt[6], lat[6], fix_lat[6], start_cnt[6], hi_len[6], hi_start[6];
    int         tick_no, last_acc, done_pulses;
    bit         rnd_mode, spur_read, run_active;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s/%s observed=%0d expected=%0d", cur_test, tag, obs, expv);
        end
    endtask

    task automatic drive_dn(input logic [5:0] d);
        {writec_done, sys_done, initreg_done, readb_done, reada_done, initc_done} = d;
    endtask

    function automatic logic [5:0] starts();
        return {writec_start, sys_start, initreg_start, readb_start, reada_start, initc_start};
    endfunction

    // One clock: observe outputs after the edge, check them, then drive dones.
    task automatic tick();
        logic [5:0] st, rise, dn;
        ev_t        e;
        @(posedge clock);
        #1;
        tick_no++;
        st   = starts();
        rise = st & ~prev_st;
        dn   = 6'b000000;
        for (int c = 0; c < 6; c++) begin
            if (prev_st[c]) begin
                if (prev_dn[c]) chk("start_falls", 32'(st[c]), 32'd0);
                else            chk("start_holds", 32'(st[c]), 32'd1);
            end
            if (prev_st[c] && !st[c]) hi_len[c] = tick_no - hi_start[c];
        end
        if (rise != 6'b000000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 32'(rise), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("start_order", 32'(rise), 32'(e.mask));
                chk("m_idx", 32'(m_idx), e.m);
                chk("n_idx", 32'(n_idx), e.n);
                chk("k_idx", 32'(k_idx), e.k);
            end
            chk("handoff_gap", tick_no - last_acc, 32'd1);
        end else if (st != 6'b000000) begin
            chk("idx_stable", 32'({m_idx, n_idx, k_idx}), 32'({prev_m, prev_n, prev_k}));
        end
        for (int c = 0; c < 6; c++) begin
            if (rise[c]) begin
                start_cnt[c]++;
                cnt[c]      = 0;
                hi_start[c] = tick_no;
                lat[c]      = rnd_mode ? int'($urandom_range(1, 10)) : fix_lat[c];
            end else if (st[c]) begin
                cnt[c]++;
            end
            dn[c] = st[c] && (cnt[c] == lat[c]);
        end
        if (ap_done) begin
            done_pulses++;
            chk("ap_ready_with_done", 32'(ap_ready), 32'd1);
            chk("starts_low_in_done", 32'(st), 32'd0);
        end else begin
            chk("ap_ready_alone", 32'(ap_ready), 32'd0);
        end
        if (run_active) chk("ap_idle_low_in_run", 32'(ap_idle), 32'd0);
        if (ap_done) run_active = 1'b0;
        if (spur_read && st[CH_READA] && cnt[CH_READA] == 0) begin
            dn[CH_SYS]    = 1'b1;
            dn[CH_WRITEC] = 1'b1;
        end
        dn = dn | force_dn;
        if ((dn & st) != 6'b000000) last_acc = tick_no;
        drive_dn(dn);
        prev_st = st;
        prev_dn = dn;
        prev_m  = m_idx;
        prev_n  = n_idx;
        prev_k  = k_idx;
    endtask

    // Expected start events of one complete run, in order.
    task automatic build_exp();
        logic [5:0] rd;
        rd = (6'b000001 << CH_READA) | (6'b000001 << CH_READB);
        exp_q.delete();
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                exp_q.push_back('{6'b000001 << CH_INITC, m, n, 0});
                for (int k = 0; k < K; k++) begin
                    exp_q.push_back('{rd, m, n, k});
                    exp_q.push_back('{6'b000001 << CH_INITREG, m, n, k});
                    exp_q.push_back('{6'b000001 << CH_SYS, m, n, k});
                end
                exp_q.push_back('{6'b000001 << CH_WRITEC, m, n, K - 1});
            end
        end
    endtask

    task automatic launch();
        build_exp();
        for (int c = 0; c < 6; c++) start_cnt[c] = 0;
        done_pulses = 0;
        ap_start    = 1'b1;
        last_acc    = tick_no;
        tick();
        ap_start    = 1'b0;
        run_active  = 1'b1;
    endtask

    task automatic run_full();
        int t;
        launch();
        t = 0;
        while (done_pulses == 0 && t < 3000) begin
            tick();
            t++;
        end
        chk("run_completes", 32'(done_pulses != 0), 32'd1);
        run_active = 1'b0;
        repeat (3) tick();
        chk("cnt_initc", start_cnt[CH_INITC], M * N);
        chk("cnt_reada", start_cnt[CH_READA], M * N * K);
        chk("cnt_readb", start_cnt[CH_READB], M * N * K);
        chk("cnt_initreg", start_cnt[CH_INITREG], M * N * K);
        chk("cnt_sys", start_cnt[CH_SYS], M * N * K);
        chk("cnt_writec", start_cnt[CH_WRITEC], M * N);
        chk("ap_done_pulses", done_pulses, 32'd1);
        chk("events_left", exp_q.size(), 32'd0);
        chk("idle_after_run", 32'(ap_idle), 32'd1);
    endtask

    initial begin : wdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset    = 1'b1;
        ap_start = 1'b0;
        force_dn = 6'b000000;
        prev_st  = 6'b000000;
        prev_dn  = 6'b000000;
        prev_m   = 8'd0;
        prev_n   = 8'd0;
        prev_k   = 8'd0;
        tick_no  = 0;
        last_acc = 0;
        rnd_mode = 1'b0;
        spur_read  = 1'b0;
        run_active = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cnt[c] = 0; lat[c] = 0; fix_lat[c] = 1; start_cnt[c] = 0; hi_len[c] = 0; hi_start[c] = 0;
        end
        drive_dn(6'b000000);
        #1;
        chk("rst_starts", 32'(starts()), 32'd0);
        chk("rst_ap_done", 32'(ap_done), 32'd0);
        chk("rst_ap_ready", 32'(ap_ready), 32'd0);
        chk("rst_ap_idle", 32'(ap_idle), 32'd1);
        chk("rst_idx", 32'({m_idx, n_idx, k_idx}), 32'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        tick();

        cur_test = "idle_spurious";
        force_dn = (6'b000001 << CH_SYS) | (6'b000001 << CH_WRITEC);
        tick();
        force_dn = 6'b000000;
        repeat (3) tick();
        chk("idle_starts", 32'(starts()), 32'd0);
        chk("idle_flag", 32'(ap_idle), 32'd1);

        cur_test = "random_latency";
        rnd_mode = 1'b1;
        run_full();

        cur_test = "read_skew";
        rnd_mode = 1'b0;
        fix_lat  = '{1, 2, 6, 1, 1, 1};
        run_full();
        chk("reada_high_cycles", hi_len[CH_READA], 32'd3);
        chk("readb_high_cycles", hi_len[CH_READB], 32'd7);

        cur_test = "same_cycle_done";
        fix_lat  = '{0, 0, 0, 0, 0, 0};
        run_full();

        cur_test = "simultaneous_read";
        fix_lat  = '{0, 3, 3, 0, 2, 0};
        run_full();

        cur_test = "read_spurious";
        rnd_mode  = 1'b1;
        spur_read = 1'b1;
        run_full();
        spur_read = 1'b0;

        cur_test = "reset_mid_sys";
        launch();
        t = 0;
        while (!(sys_start === 1'b1 && m_idx == 8'd1 && n_idx == 8'd0) && t < 3000) begin
            tick();
            t++;
        end
        chk("reached_sys_1_0", 32'(sys_start), 32'd1);
        #2;
        reset = 1'b1;
        drive_dn(6'b111111);
        #1;
        chk("async_starts_low", 32'(starts()), 32'd0);
        chk("async_idle", 32'(ap_idle), 32'd1);
        chk("async_ap_done", 32'(ap_done), 32'd0);
        chk("async_idx", 32'({m_idx, n_idx, k_idx}), 32'd0);
        repeat (2) @(posedge clock);
        #3;
        drive_dn(6'b000000);
        reset      = 1'b0;
        prev_st    = 6'b000000;
        prev_dn    = 6'b000000;
        run_active = 1'b0;
        exp_q.delete();
        tick();
        chk("post_reset_idle", 32'(ap_idle), 32'd1);
        cur_test = "restart_after_reset";
        run_full();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
